// File: rtl/step_ctrl.sv
// Button front end and STOP/RUN/RST controller for the single-cycle core.
// Makes press pulses, step/run clock enables, stretched core reset and a display-select index.
module step_ctrl #(
    parameter int unsigned RUN_DIV      = 50000000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned SEL_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       buttons,
    output logic [4:0]       btn_rise,
    output logic             step_en,
    output logic             running,
    output logic             cpu_rst,
    output logic [SEL_W-1:0] disp_sel
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_STOP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [31:0] RUN_LAST = 32'(RUN_DIV - 1);
    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] DELAY    = 32'(REPEAT_DELAY);
    localparam logic [31:0] RATE     = 32'(REPEAT_RATE);

    state_t      state, state_next;
    logic [4:0]  btn_q;
    logic [31:0] rst_cnt, rst_cnt_next;
    logic [31:0] run_cnt, run_cnt_next;
    logic [31:0] hold_cnt, hold_next;
    logic [31:0] hold_inc;
    logic        rep_flag, rep_next;
    logic        armed, armed_next;
    logic        step_next;

    // btn_q resets high so a button held through reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q    <= '1;
            btn_rise <= '0;
        end else begin
            btn_q    <= buttons;
            btn_rise <= buttons & ~btn_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RST;
            rst_cnt  <= '0;
            run_cnt  <= '0;
            hold_cnt <= '0;
            rep_flag <= 1'b0;
            armed    <= 1'b0;
            step_en  <= 1'b0;
        end else begin
            state    <= state_next;
            rst_cnt  <= rst_cnt_next;
            run_cnt  <= run_cnt_next;
            hold_cnt <= hold_next;
            rep_flag <= rep_next;
            armed    <= armed_next;
            step_en  <= step_next;
        end
    end

    assign hold_inc = hold_cnt + 32'd1;

    // armed is set only by a real step press, so a level held since STOP entry never auto-repeats.
    always_comb begin
        state_next   = state;
        rst_cnt_next = rst_cnt;
        run_cnt_next = run_cnt;
        hold_next    = hold_cnt;
        rep_next     = rep_flag;
        armed_next   = armed;
        step_next    = 1'b0;
        if (btn_rise[2]) begin
            state_next   = ST_RST;
            rst_cnt_next = '0;
            hold_next    = '0;
            rep_next     = 1'b0;
            armed_next   = 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    hold_next  = '0;
                    rep_next   = 1'b0;
                    armed_next = 1'b0;
                    if (rst_cnt == RST_LAST) begin
                        state_next   = ST_STOP;
                        rst_cnt_next = '0;
                    end else begin
                        rst_cnt_next = rst_cnt + 32'd1;
                    end
                end
                ST_STOP: begin
                    if (btn_rise[1]) begin
                        state_next   = ST_RUN;
                        run_cnt_next = '0;
                        hold_next    = '0;
                        rep_next     = 1'b0;
                        armed_next   = 1'b0;
                    end else if (btn_rise[0]) begin
                        step_next  = 1'b1;
                        hold_next  = '0;
                        rep_next   = 1'b0;
                        armed_next = 1'b1;
                    end else if (buttons[0] && armed) begin
                        if (hold_inc == (rep_flag ? RATE : DELAY)) begin
                            step_next = 1'b1;
                            hold_next = '0;
                            rep_next  = 1'b1;
                        end else begin
                            hold_next = hold_inc;
                        end
                    end else begin
                        hold_next  = '0;
                        rep_next   = 1'b0;
                        armed_next = 1'b0;
                    end
                end
                ST_RUN: begin
                    hold_next  = '0;
                    rep_next   = 1'b0;
                    armed_next = 1'b0;
                    if (btn_rise[1]) begin
                        state_next = ST_STOP;
                    end else if (run_cnt == RUN_LAST) begin
                        run_cnt_next = '0;
                        step_next    = 1'b1;
                    end else begin
                        run_cnt_next = run_cnt + 32'd1;
                    end
                end
                default: state_next = ST_RST;
            endcase
        end
    end

    always_comb begin
        running = (state == ST_RUN);
        cpu_rst = (state == ST_RST);
    end

    // Simultaneous up and down presses cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_sel <= '0;
        end else begin
            case ({btn_rise[4], btn_rise[3]})
                2'b10:   disp_sel <= disp_sel + SEL_W'(1);
                2'b01:   disp_sel <= disp_sel - SEL_W'(1);
                default: disp_sel <= disp_sel;
            endcase
        end
    end

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: step_en pulses are scoreboarded by cycle stamp,
// other outputs are checked at fixed offsets from the stimulus.
module tb_step_ctrl;

    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [4:0]       buttons = '0;
    logic [4:0]       btn_rise;
    logic             step_en;
    logic             running;
    logic             cpu_rst;
    logic [SEL_W-1:0] disp_sel;

    step_ctrl #(
        .RUN_DIV     (4),
        .REPEAT_DELAY(8),
        .REPEAT_RATE (3),
        .RST_CYCLES  (4),
        .SEL_W       (SEL_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .buttons (buttons),
        .btn_rise(btn_rise),
        .step_en (step_en),
        .running (running),
        .cpu_rst (cpu_rst),
        .disp_sel(disp_sel)
    );

    // clock and cycle stamp
    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0]      exp_q[$];
    logic [SEL_W-1:0] sel_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush_steps(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic sel_press(input logic [4:0] mask, input logic [SEL_W-1:0] exp);
        buttons = buttons | mask;
        sel_q.push_back(exp);
        tick(1);
        buttons = buttons & ~mask;
        tick(1);
        check("disp_sel", 32'(disp_sel), 32'(sel_q.pop_front()));
    endtask

    // step_en scoreboard: every pulse must match the oldest expected cycle stamp
    always @(negedge clk) begin
        if (step_en === 1'b1) begin
            if (exp_q.size() == 0) check("step_en_unexpected", 32'(step_en), 0);
            else                   check("step_en_cycle", cyc, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]      c;
        logic [SEL_W-1:0] exp_sel;

        #2 rst_n = 1'b0;
        tick(2);
        check("reset_btn_rise", 32'(btn_rise), 0);
        check("reset_step_en", 32'(step_en), 0);
        check("reset_running", 32'(running), 0);
        check("reset_cpu_rst", 32'(cpu_rst), 1);
        check("reset_disp_sel", 32'(disp_sel), 0);

        // reset release: cpu_rst held for 4 edges
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_hold", 32'(cpu_rst), 1);
            check("rst_running", 32'(running), 0);
        end
        tick(1);
        check("rst_drop", 32'(cpu_rst), 0);
        check("stop_running", 32'(running), 0);
        tick(4);
        flush_steps("t1_steps");

        // single step press, 2 cycles
        c = cyc;
        buttons[0] = 1'b1;
        exp_q.push_back(c + 32'd2);
        tick(1);
        check("rise0_pulse", 32'(btn_rise[0]), 1);
        tick(1);
        buttons[0] = 1'b0;
        check("rise0_single", 32'(btn_rise[0]), 0);
        tick(6);
        flush_steps("t2_single");

        // held step: first pulse, then +8, +11, +14, +17
        c = cyc;
        buttons[0] = 1'b1;
        exp_q.push_back(c + 32'd2);
        exp_q.push_back(c + 32'd10);
        exp_q.push_back(c + 32'd13);
        exp_q.push_back(c + 32'd16);
        exp_q.push_back(c + 32'd19);
        tick(20);
        buttons[0] = 1'b0;
        tick(8);
        flush_steps("t2_repeat");

        // RUN: pulse every 4th cycle, step button ignored, toggle back to STOP
        c = cyc;
        buttons[1] = 1'b1;
        exp_q.push_back(c + 32'd6);
        exp_q.push_back(c + 32'd10);
        exp_q.push_back(c + 32'd14);
        tick(1);
        buttons[1] = 1'b0;
        check("run_pre", 32'(running), 0);
        tick(1);
        check("run_on", 32'(running), 1);
        buttons[0] = 1'b1;
        tick(1);
        buttons[0] = 1'b0;
        tick(12);
        buttons[1] = 1'b1;
        tick(1);
        buttons[1] = 1'b0;
        check("run_before_stop", 32'(running), 1);
        tick(1);
        check("run_off", 32'(running), 0);
        tick(8);
        flush_steps("t3_steps");

        // CPU reset from RUN
        buttons[1] = 1'b1;
        tick(1);
        buttons[1] = 1'b0;
        tick(2);
        buttons[2] = 1'b1;
        tick(1);
        buttons[2] = 1'b0;
        check("rst4_pre_run", 32'(running), 1);
        check("rst4_pre_cpu", 32'(cpu_rst), 0);
        tick(1);
        check("rst4_running", 32'(running), 0);
        check("rst4_cpu", 32'(cpu_rst), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst4_hold", 32'(cpu_rst), 1);
        end
        tick(1);
        check("rst4_release", 32'(cpu_rst), 0);
        check("rst4_stop", 32'(running), 0);
        tick(2);

        // run/stop and reset pressed together in STOP: reset wins
        buttons = 5'b00110;
        tick(1);
        buttons = '0;
        tick(1);
        check("both_cpu", 32'(cpu_rst), 1);
        check("both_running", 32'(running), 0);
        tick(4);
        check("both_release", 32'(cpu_rst), 0);
        check("both_stop", 32'(running), 0);
        flush_steps("t4_steps");

        // display select: up x5, down x2 (through wrap), both together
        exp_sel = '0;
        for (int i = 0; i < 5; i++) begin
            exp_sel = exp_sel + 2'd1;
            sel_press(5'b10000, exp_sel);
        end
        for (int i = 0; i < 2; i++) begin
            exp_sel = exp_sel - 2'd1;
            sel_press(5'b01000, exp_sel);
        end
        sel_press(5'b11000, exp_sel);

        // step held across rst_n: no press event, no repeat afterwards
        c = cyc;
        buttons[0] = 1'b1;
        exp_q.push_back(c + 32'd2);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("async_cpu_rst", 32'(cpu_rst), 1);
        check("async_step_en", 32'(step_en), 0);
        check("async_btn_rise", 32'(btn_rise), 0);
        check("async_disp_sel", 32'(disp_sel), 0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            check("held_rise0", 32'(btn_rise[0]), 0);
        end
        buttons[0] = 1'b0;
        tick(2);
        flush_steps("t6_held");

        // rst_n mid-RUN aborts before the first run pulse
        buttons[1] = 1'b1;
        tick(1);
        buttons[1] = 1'b0;
        tick(2);
        check("t6_run", 32'(running), 1);
        rst_n = 1'b0;
        #1;
        check("abort_running", 32'(running), 0);
        check("abort_cpu_rst", 32'(cpu_rst), 1);
        check("abort_step_en", 32'(step_en), 0);
        tick(4);
        rst_n = 1'b1;
        tick(8);
        check("abort_after_running", 32'(running), 0);
        check("abort_after_cpu_rst", 32'(cpu_rst), 0);
        flush_steps("t6_run_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
